// File: rtl/complex_mult_pkg.sv
// Shared widths, FSM encoding and product tags for the sequential complex multiplier.
// Tags travel with each partial product so the accumulator knows where it belongs.
package complex_mult_pkg;

  localparam int CM_W       = 8;
  localparam int CM_MUL_LAT = 2;
  localparam int CM_PW      = 2 * CM_W;
  localparam int CM_RW      = 2 * CM_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Issue order equals tag value, so the issue counter doubles as the tag.
  localparam logic [1:0] P_RR = 2'd0;
  localparam logic [1:0] P_II = 2'd1;
  localparam logic [1:0] P_RI = 2'd2;
  localparam logic [1:0] P_IR = 2'd3;

endpackage

// File: rtl/cmul_real_mult.sv
// Registered signed W x W -> 2W multiplier with valid and tag riding alongside.
// Latency MUL_LAT clocks, fully pipelined; no backpressure (always accepts).
module cmul_real_mult
  import complex_mult_pkg::*;
#(
  parameter int W       = CM_W,
  parameter int MUL_LAT = CM_MUL_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [1:0]       in_tag,
  input  logic [W-1:0]     a_dat,
  input  logic [W-1:0]     b_dat,
  output logic             out_vld,
  output logic [1:0]       out_tag,
  output logic [2*W-1:0]   out_dat
);

  localparam int PW = 2 * W;

  logic signed [PW-1:0]       a_ext;
  logic signed [PW-1:0]       b_ext;
  logic signed [PW-1:0]       prod;
  logic [MUL_LAT-1:0]         vld_q, vld_d;
  logic [MUL_LAT-1:0][1:0]    tag_q, tag_d;
  logic [MUL_LAT-1:0][PW-1:0] dat_q, dat_d;

  // Both operands are widened before multiplying so -2^(W-1) squared is exact.
  always_comb begin
    a_ext    = {{W{a_dat[W-1]}}, a_dat};
    b_ext    = {{W{b_dat[W-1]}}, b_dat};
    prod     = a_ext * b_ext;
    vld_d    = '0;
    tag_d    = '0;
    dat_d    = '0;
    vld_d[0] = in_vld;
    tag_d[0] = in_tag;
    dat_d[0] = prod;
    for (int i = 1; i < MUL_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      tag_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q[MUL_LAT-1];
  assign out_tag = tag_q[MUL_LAT-1];
  assign out_dat = dat_q[MUL_LAT-1];

endmodule

// File: rtl/complex_mult_seq.sv
// Sequential complex multiply sharing one real multiplier over four partial products.
// Accept at edge T, result at T+4+MUL_LAT+1; result held until out_ready, one op in flight.
module complex_mult_seq
  import complex_mult_pkg::*;
#(
  parameter int W       = CM_W,
  parameter int MUL_LAT = CM_MUL_LAT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a_re,
  input  logic [W-1:0]   a_im,
  input  logic [W-1:0]   b_re,
  input  logic [W-1:0]   b_im,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W:0]   res_re,
  output logic [2*W:0]   res_im
);

  localparam int PW = 2 * W;
  localparam int RW = 2 * W + 1;

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [W-1:0]  a_re_q, a_re_d, a_im_q, a_im_d;
  logic [W-1:0]  b_re_q, b_re_d, b_im_q, b_im_d;
  logic [RW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [RW-1:0] res_re_q, res_re_d, res_im_q, res_im_d;
  logic          out_valid_q, out_valid_d;

  logic          mul_in_vld;
  logic [W-1:0]  mul_a, mul_b;
  logic          mul_out_vld;
  logic [1:0]    mul_out_tag;
  logic [PW-1:0] mul_out_dat;
  logic [RW-1:0] prod_ext;

  always_comb begin
    mul_in_vld = (state_q == ISSUE);
    mul_a      = a_re_q;
    mul_b      = b_re_q;
    case (cnt_q)
      P_RR:    begin mul_a = a_re_q; mul_b = b_re_q; end
      P_II:    begin mul_a = a_im_q; mul_b = b_im_q; end
      P_RI:    begin mul_a = a_re_q; mul_b = b_im_q; end
      default: begin mul_a = a_im_q; mul_b = b_re_q; end
    endcase
  end

  cmul_real_mult #(
    .W       (W),
    .MUL_LAT (MUL_LAT)
  ) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (mul_in_vld),
    .in_tag  (cnt_q),
    .a_dat   (mul_a),
    .b_dat   (mul_b),
    .out_vld (mul_out_vld),
    .out_tag (mul_out_tag),
    .out_dat (mul_out_dat)
  );

  assign prod_ext = {mul_out_dat[PW-1], mul_out_dat};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_re_d      = a_re_q;
    a_im_d      = a_im_q;
    b_re_d      = b_re_q;
    b_im_d      = b_im_q;
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    res_re_d    = res_re_q;
    res_im_d    = res_im_q;
    out_valid_d = out_valid_q;

    if (mul_out_vld) begin
      case (mul_out_tag)
        P_RR:    acc_re_d = acc_re_q + prod_ext;
        P_II:    acc_re_d = acc_re_q - prod_ext;
        P_RI:    acc_im_d = acc_im_q + prod_ext;
        default: acc_im_d = acc_im_q + prod_ext;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_re_d   = a_re;
          a_im_d   = a_im;
          b_re_d   = b_re;
          b_im_d   = b_im;
          acc_re_d = '0;
          acc_im_d = '0;
          cnt_d    = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == P_IR) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mul_out_vld && (mul_out_tag == P_IR)) begin
          state_d = DONE;
        end
      end
      default: begin
        // First DONE cycle publishes the sums; afterwards hold until taken.
        if (!out_valid_q) begin
          res_re_d    = acc_re_q;
          res_im_d    = acc_im_q;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_re_q      <= '0;
      a_im_q      <= '0;
      b_re_q      <= '0;
      b_im_q      <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      res_re_q    <= '0;
      res_im_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_re_q      <= a_re_d;
      a_im_q      <= a_im_d;
      b_re_q      <= b_re_d;
      b_im_q      <= b_im_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      res_re_q    <= res_re_d;
      res_im_q    <= res_im_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign res_re    = res_re_q;
  assign res_im    = res_im_q;

endmodule
